// File: rtl/sync_updown_counter_mod.sv
// Parametrised up/down counter: programmable modulus, synchronous load, wrap or saturate, registered terminal-count pulse.
// Optional snapshot capture port enabled by defining UDCNT_SNAPSHOT_EN.
module sync_updown_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_MAX  = (2**WIDTH) - 1,
  parameter int unsigned RST_VAL  = 0,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UDCNT_SNAPSHOT_EN
  input  logic             snap,
  output logic [WIDTH-1:0] snap_q,
  output logic             snap_vld,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  // Next count: load clamps to the modulus, limits wrap or hold and raise tc.
  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (en) begin
      if (dir) begin
        if (q >= MAX_Q) begin
          tc_nxt = 1'b1;
          q_nxt  = SAT ? MAX_Q : '0;
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          tc_nxt = 1'b1;
          q_nxt  = SAT ? '0 : MAX_Q;
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= RST_Q;
      tc <= 1'b0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);

`ifdef UDCNT_SNAPSHOT_EN
  // Capture the pre-update count; valid stays sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q   <= '0;
      snap_vld <= 1'b0;
    end else if (snap) begin
      snap_q   <= q;
      snap_vld <= 1'b1;
    end
  end
`endif

endmodule
